// File: rtl/ei_mac_pkg.sv
// Shared constants and types for the MAC10 feeder and its lane packer.
package ei_mac_pkg;

    localparam int LANES = 10;
    localparam int DW    = 8;
    localparam int ACCW  = 32;

    typedef logic [DW-1:0] opnd_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FILL,
        ISSUE,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/ei_lane_packer.sv
// Collects serial operand pairs into LANES-wide vectors; lane 0 holds the first pair of a beat.
module ei_lane_packer #(
    parameter int LANES = 10,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic                wr_last,
    input  logic [DW-1:0]       wr_a,
    input  logic [DW-1:0]       wr_b,
    output logic [LANES*DW-1:0] a_vec,
    output logic [LANES*DW-1:0] b_vec,
    output logic                beat_end
);

    localparam int IDXW = $clog2(LANES + 1);

    logic [IDXW-1:0] lane_idx_reg;
    logic            full;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane_idx_reg <= '0;
        end else if (wr_en) begin
            lane_idx_reg <= lane_idx_reg + IDXW'(1);
        end
    end

    // The write that lands in the last lane, or carries the job's final pair, closes the beat.
    assign full     = (lane_idx_reg == IDXW'(LANES - 1));
    assign beat_end = wr_en & (full | wr_last);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0] a_reg;
            logic [DW-1:0] b_reg;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (wr_en && (lane_idx_reg == IDXW'(gi))) begin
                    a_reg <= wr_a;
                    b_reg <= wr_b;
                end
            end

            assign a_vec[DW*gi +: DW] = a_reg;
            assign b_vec[DW*gi +: DW] = b_reg;
        end
    endgenerate

endmodule

// File: rtl/ei_mac10_feeder.sv
// Packs a serial (a,b) stream into MAC10 beats, clears the MAC per job and returns one dot product per job.
module ei_mac10_feeder #(
    parameter int LANES     = ei_mac_pkg::LANES,
    parameter int DW        = ei_mac_pkg::DW,
    parameter int ACCW      = ei_mac_pkg::ACCW,
    parameter int LENW      = 16,
    parameter int LAT       = 3,
    parameter int DRAIN_TMO = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LENW-1:0]     cfg_len,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_a,
    input  logic [DW-1:0]       in_b,
    output logic                mac_en,
    output logic                mac_clr_acc,
    output logic                mac_valid_in,
    output logic [LANES*DW-1:0] mac_a_vec,
    output logic [LANES*DW-1:0] mac_b_vec,
    input  logic [ACCW-1:0]     mac_acc_out,
    input  logic                mac_valid_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACCW-1:0]     res_data,
    output logic                res_err
);

    import ei_mac_pkg::*;

    // Sized so the drain counter can also span a full pipeline flight.
    localparam int TMOW = $clog2(DRAIN_TMO + LAT + 1);

    feeder_state_t   state_reg;
    logic [LENW-1:0] remaining_reg;
    logic [LENW-1:0] issued_reg;
    logic [LENW-1:0] returned_reg;
    logic [TMOW-1:0] tmo_reg;
    logic [ACCW-1:0] last_acc_reg;
    logic            busy_reg;
    logic            mac_en_reg;
    logic            mac_clr_acc_reg;
    logic            mac_valid_in_reg;
    logic            res_valid_reg;
    logic            res_err_reg;
    logic [ACCW-1:0] res_data_reg;

    logic            wr_en;
    logic            wr_last;
    logic            beat_end;
    logic            pack_clr;
    logic            ret_live;

    assign wr_en    = (state_reg == FILL) && in_valid;
    assign wr_last  = (remaining_reg == LENW'(1));
    // Lanes are wiped while CLEAR runs and on the edge leaving ISSUE, so a partial beat pads with zeros.
    assign pack_clr = (state_reg == CLEAR) || (state_reg == ISSUE);
    assign ret_live = (state_reg == FILL) || (state_reg == ISSUE) ||
                      (state_reg == DRAIN) || (state_reg == DONE);

    ei_lane_packer #(
        .LANES (LANES),
        .DW    (DW)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (pack_clr),
        .wr_en    (wr_en),
        .wr_last  (wr_last),
        .wr_a     (in_a),
        .wr_b     (in_b),
        .a_vec    (mac_a_vec),
        .b_vec    (mac_b_vec),
        .beat_end (beat_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            remaining_reg    <= '0;
            issued_reg       <= '0;
            returned_reg     <= '0;
            tmo_reg          <= '0;
            last_acc_reg     <= '0;
            busy_reg         <= 1'b0;
            mac_en_reg       <= 1'b0;
            mac_clr_acc_reg  <= 1'b0;
            mac_valid_in_reg <= 1'b0;
            res_valid_reg    <= 1'b0;
            res_err_reg      <= 1'b0;
            res_data_reg     <= '0;
        end else begin
            mac_en_reg       <= 1'b1;
            mac_clr_acc_reg  <= 1'b0;
            mac_valid_in_reg <= 1'b0;

            if (ret_live && mac_valid_out) begin
                returned_reg <= returned_reg + LENW'(1);
                last_acc_reg <= mac_acc_out;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (cfg_len == '0) begin
                            state_reg     <= DONE;
                            res_valid_reg <= 1'b1;
                            res_data_reg  <= '0;
                            res_err_reg   <= 1'b0;
                        end else begin
                            remaining_reg   <= cfg_len;
                            state_reg       <= CLEAR;
                            mac_clr_acc_reg <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    issued_reg   <= '0;
                    returned_reg <= '0;
                    last_acc_reg <= '0;
                    tmo_reg      <= '0;
                    state_reg    <= FILL;
                end
                FILL: begin
                    if (in_valid) begin
                        remaining_reg <= remaining_reg - LENW'(1);
                        if (beat_end) begin
                            state_reg        <= ISSUE;
                            mac_valid_in_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    issued_reg <= issued_reg + LENW'(1);
                    tmo_reg    <= '0;
                    state_reg  <= (remaining_reg != '0) ? FILL : DRAIN;
                end
                DRAIN: begin
                    if (returned_reg == issued_reg) begin
                        state_reg     <= DONE;
                        res_valid_reg <= 1'b1;
                        res_data_reg  <= last_acc_reg;
                        res_err_reg   <= 1'b0;
                    end else if (tmo_reg == TMOW'(DRAIN_TMO)) begin
                        state_reg     <= DONE;
                        res_valid_reg <= 1'b1;
                        res_data_reg  <= '0;
                        res_err_reg   <= 1'b1;
                    end else if (mac_valid_out) begin
                        tmo_reg <= '0;
                    end else begin
                        tmo_reg <= tmo_reg + TMOW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_reg     <= IDLE;
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state_reg == FILL);
    assign busy         = busy_reg;
    assign mac_en       = mac_en_reg;
    assign mac_clr_acc  = mac_clr_acc_reg;
    assign mac_valid_in = mac_valid_in_reg;
    assign res_valid    = res_valid_reg;
    assign res_err      = res_err_reg;
    assign res_data     = res_data_reg;

endmodule

// File: tb/tb_ei_mac10_feeder.sv
// Directed bench for ei_mac10_feeder driving a 3-stage behavioural MAC10 with a scoreboard of job results.
module tb_ei_mac10_feeder;

    localparam int LANES     = 10;
    localparam int DW        = 8;
    localparam int ACCW      = 32;
    localparam int LENW      = 16;
    localparam int LAT       = 3;
    localparam int DRAIN_TMO = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [LENW-1:0]     cfg_len = '0;
    logic                busy;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DW-1:0]       in_a = '0;
    logic [DW-1:0]       in_b = '0;
    logic                mac_en;
    logic                mac_clr_acc;
    logic                mac_valid_in;
    logic [LANES*DW-1:0] mac_a_vec;
    logic [LANES*DW-1:0] mac_b_vec;
    logic [ACCW-1:0]     mac_acc_out = '0;
    logic                mac_valid_out = 1'b0;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [ACCW-1:0]     res_data;
    logic                res_err;

    always #5 clk = ~clk;

    ei_mac10_feeder #(
        .LANES     (LANES),
        .DW        (DW),
        .ACCW      (ACCW),
        .LENW      (LENW),
        .LAT       (LAT),
        .DRAIN_TMO (DRAIN_TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .mac_en        (mac_en),
        .mac_clr_acc   (mac_clr_acc),
        .mac_valid_in  (mac_valid_in),
        .mac_a_vec     (mac_a_vec),
        .mac_b_vec     (mac_b_vec),
        .mac_acc_out   (mac_acc_out),
        .mac_valid_out (mac_valid_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_err       (res_err)
    );

    // Behavioural MAC10: clr/valid travel LAT stages; the accumulator updates at the output stage.
    logic            stub = 1'b0;
    logic            s1_v = 1'b0, s2_v = 1'b0, s1_c = 1'b0, s2_c = 1'b0;
    logic [ACCW-1:0] s1_d = '0, s2_d = '0, m_acc = '0;

    function automatic logic [ACCW-1:0] dot(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b);
        logic [ACCW-1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) s += ACCW'(a[DW*i +: DW]) * ACCW'(b[DW*i +: DW]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0; s2_v <= 1'b0; s1_c <= 1'b0; s2_c <= 1'b0;
            mac_valid_out <= 1'b0;
        end else if (mac_en) begin
            s1_v <= mac_valid_in; s1_c <= mac_clr_acc; s1_d <= dot(mac_a_vec, mac_b_vec);
            s2_v <= s1_v;         s2_c <= s1_c;        s2_d <= s1_d;
            mac_valid_out <= s2_v && !stub;
            if (s2_c) begin
                m_acc <= '0;
            end else if (s2_v) begin
                m_acc       <= m_acc + s2_d;
                mac_acc_out <= m_acc + s2_d;
            end
        end
    end

    int                  beats = 0, clrs = 0, overlap = 0;
    logic [LANES*DW-1:0] last_a = '0;

    always @(posedge clk) begin
        if (!rst) begin
            if (mac_valid_in) begin
                beats  <= beats + 1;
                last_a <= mac_a_vec;
            end
            if (mac_clr_acc) clrs <= clrs + 1;
            if (mac_clr_acc && mac_valid_in) overlap <= overlap + 1;
        end
    end

    typedef struct {
        logic [ACCW-1:0] data;
        logic            err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] pa[$];
    logic [DW-1:0] pb[$];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        cfg_len = LENW'(len);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic collect(input int stall, output int waited);
        exp_t e;
        waited = 0;
        while (res_valid !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("res_valid_seen", res_valid, 1);
        chk("scoreboard_pending", exp_q.size(), 1);
        e.data = '1;
        e.err  = 1'b1;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_err", res_err, e.err);
        $display("job result: data=%0d err=%0d expected data=%0d err=%0d", res_data, res_err, e.data, e.err);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_data", res_data, e.data);
            chk("hold_valid", res_valid, 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("res_valid_after_done", res_valid, 0);
    endtask

    task automatic run_job(input int gap_max, input int stall, input bit poke_start);
        exp_t            e;
        logic [ACCW-1:0] s;
        int              b0, c0, waited, len;
        len = pa.size();
        s   = '0;
        for (int i = 0; i < len; i++) s += ACCW'(pa[i]) * ACCW'(pb[i]);
        e.data = s;
        e.err  = 1'b0;
        exp_q.push_back(e);
        b0 = beats;
        c0 = clrs;
        do_start(len);
        for (int i = 0; i < len; i++) begin
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
            if (poke_start && i == 1) begin
                start   = 1'b1;
                cfg_len = LENW'(3);
            end
            send_pair(pa[i], pb[i]);
            start = 1'b0;
        end
        in_valid = 1'b0;
        collect(stall, waited);
        if (len == 0) chk("zero_len_latency_ok", waited <= 1, 1);
        chk("beats", beats - b0, (len + LANES - 1) / LANES);
        chk("clr_pulses", clrs - c0, (len == 0) ? 0 : 1);
    endtask

    initial begin
        int waited;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_a_vec", mac_a_vec, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mac_en_after_rst", mac_en, 1);

        // Job 1: ten mixed pairs, one full beat.
        pa = '{8'd3, 8'd10, 8'd5, 8'd1, 8'd2, 8'd4, 8'd8, 8'd3, 8'd9, 8'd2};
        pb = '{8'd4, 8'd2,  8'd5, 8'd7, 8'd9, 8'd6, 8'd1, 8'd3, 8'd0, 8'd2};
        run_job(0, 0, 1'b0);

        // Job 2: the same ten then (k,k) for k=1..10.
        for (int k = 1; k <= 10; k++) begin pa.push_back(DW'(k)); pb.push_back(DW'(k)); end
        run_job(0, 0, 1'b0);

        // Job 3: (k,k) k=1..10, with a start pulse mid-job that must be ignored.
        pa.delete(); pb.delete();
        for (int k = 1; k <= 10; k++) begin pa.push_back(DW'(k)); pb.push_back(DW'(k)); end
        run_job(0, 0, 1'b1);

        // Job 4: thirteen pairs, partial second beat.
        for (int k = 11; k <= 13; k++) begin pa.push_back(DW'(k)); pb.push_back(DW'(k)); end
        run_job(0, 0, 1'b0);
        chk("pad_lanes_zero", last_a[LANES*DW-1:3*DW], 0);
        chk("beat2_lane0", last_a[DW-1:0], 11);
        chk("beat2_lane2", last_a[3*DW-1:2*DW], 13);

        pa.delete(); pb.delete();
        run_job(0, 0, 1'b0);

        pa = '{8'd255};
        pb = '{8'd255};
        run_job(4, 5, 1'b0);

        // Reset mid-FILL, then a clean job.
        do_start(10);
        for (int i = 0; i < 3; i++) send_pair(8'd1, 8'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_mac_en", mac_en, 0);
        chk("midrst_clr", mac_clr_acc, 0);
        chk("midrst_valid_in", mac_valid_in, 0);
        chk("midrst_a_vec", mac_a_vec, 0);
        chk("midrst_res_valid", res_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        pa.delete(); pb.delete();
        for (int k = 0; k < 10; k++) begin pa.push_back(8'd1); pb.push_back(8'd1); end
        run_job(0, 0, 1'b0);

        // MAC never returns: drain timeout.
        stub   = 1'b1;
        e.data = '0;
        e.err  = 1'b1;
        exp_q.push_back(e);
        do_start(1);
        send_pair(8'd7, 8'd9);
        in_valid = 1'b0;
        collect(0, waited);
        chk("tmo_latency_ok", waited >= DRAIN_TMO, 1);
        stub = 1'b0;

        chk("clr_valid_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
